// File: rtl/lt24_pixel_writer.sv
// lt24_pixel_writer
//   Host-side controller for the LT24 panel's 8080-style write bus. After
//   reset it pulses the panel reset, wakes the controller and programs the
//   pixel format. It then takes (x, y, colour) requests. A request that lands
//   on the panel's current write cursor goes out as a single 0x2C payload
//   write. Any other request first re-opens the window with CASET, PASET and
//   0x2C.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   pixelWrite/Ready      request handshake; accepted when both are high
//   xAddr, yAddr          pixel column / row
//   pixelData             RGB565 colour
//   LT24Wr_n/Rd_n/CS_n    bus strobes and chip select (all registered)
//   LT24RS, LT24Data      0 = command, 1 = payload; bytes sit in [7:0]
//   LT24Reset_n           panel hardware reset
//   LT24LCDOn             display enable, high once init is complete
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | panel reset held low for RESET_CYCLES
// RST_WAIT | panel reset released, CS asserted, wake-up wait
// INIT     | 0x11, wake wait, 0x36/MADCTL, 0x3A/0x55, 0x29
// IDLE     | pixelReady high, waiting for a request
// WINDOW   | CASET + PASET + 0x2C (11 writes)
// DATA     | one colour payload write
module lt24_pixel_writer #(
    parameter int         WIDTH        = 240,
    parameter int         HEIGHT       = 320,
    parameter logic [7:0] MADCTL       = 8'h08,
    parameter int         RESET_CYCLES = 16,
    parameter int         WAKE_CYCLES  = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pixelWrite,
    output logic        pixelReady,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Reset_n,
    output logic [15:0] LT24Data,
    output logic        LT24LCDOn
);

    typedef enum logic [2:0] {RST_HOLD, RST_WAIT, INIT, IDLE, WINDOW, DATA} state_t;

    localparam logic [15:0] RESET_LOAD = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] WAKE_LOAD  = 16'(WAKE_CYCLES - 1);
    localparam logic [15:0] X_LAST     = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST     = 16'(HEIGHT - 1);
    localparam logic [8:0]  X_MAX      = 9'(WIDTH - 1);
    localparam logic [9:0]  Y_MAX      = 10'(HEIGHT - 1);
    localparam logic [3:0]  INIT_WAIT  = 4'd1;   // INIT step that is a delay, not a write
    localparam logic [3:0]  INIT_LAST  = 4'd6;
    localparam logic [3:0]  WIN_LAST   = 4'd10;
    localparam logic        CMD        = 1'b0;
    localparam logic        PAR        = 1'b1;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  step, step_n;
    logic        phase, phase_n;     // 0 = strobe low, 1 = strobe high
    logic        accept, win_done, data_done;
    logic        writing_n;
    logic [16:0] word_n;

    logic [7:0]  px, exp_x, win_x;
    logic [8:0]  py, exp_y, win_y;
    logic [15:0] pcol;
    logic        stream_valid;
    logic        in_range, stream_hit;
    logic [8:0]  x_inc;
    logic [9:0]  y_inc;

    logic        bus_wr_n, bus_rs, bus_cs_n, bus_reset_n, lcd_on, ready;
    logic [15:0] bus_data;

    // {RS, Data} for a given write slot of a sequence.
    function automatic logic [16:0] write_word(input state_t s, input logic [3:0] st,
                                               input logic [7:0] x, input logic [8:0] y,
                                               input logic [15:0] col);
        logic [16:0] w;
        w = {PAR, 16'h0000};
        case (s)
            INIT: begin
                case (st)
                    4'd0:    w = {CMD, 16'h0011};
                    4'd2:    w = {CMD, 16'h0036};
                    4'd3:    w = {PAR, 8'h00, MADCTL};
                    4'd4:    w = {CMD, 16'h003A};
                    4'd5:    w = {PAR, 16'h0055};
                    4'd6:    w = {CMD, 16'h0029};
                    default: w = {PAR, 16'h0000};
                endcase
            end
            WINDOW: begin
                case (st)
                    4'd0:    w = {CMD, 16'h002A};
                    4'd1:    w = {PAR, 16'h0000};
                    4'd2:    w = {PAR, 8'h00, x};
                    4'd3:    w = {PAR, 8'h00, X_LAST[15:8]};
                    4'd4:    w = {PAR, 8'h00, X_LAST[7:0]};
                    4'd5:    w = {CMD, 16'h002B};
                    4'd6:    w = {PAR, 15'h0000, y[8]};
                    4'd7:    w = {PAR, 8'h00, y[7:0]};
                    4'd8:    w = {PAR, 8'h00, Y_LAST[15:8]};
                    4'd9:    w = {PAR, 8'h00, Y_LAST[7:0]};
                    4'd10:   w = {CMD, 16'h002C};
                    default: w = {PAR, 16'h0000};
                endcase
            end
            DATA:    w = {PAR, col};
            default: w = {PAR, 16'h0000};
        endcase
        return w;
    endfunction

    assign in_range   = ({1'b0, xAddr} <= X_MAX) && ({1'b0, yAddr} <= Y_MAX);
    assign stream_hit = stream_valid && (xAddr == exp_x) && (yAddr == exp_y);
    assign x_inc      = {1'b0, px} + 9'd1;
    assign y_inc      = {1'b0, py} + 10'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RST_HOLD;
            cnt          <= RESET_LOAD;
            step         <= '0;
            phase        <= 1'b0;
            px           <= '0;
            py           <= '0;
            pcol         <= '0;
            exp_x        <= '0;
            exp_y        <= '0;
            win_x        <= '0;
            win_y        <= '0;
            stream_valid <= 1'b0;
            bus_wr_n     <= 1'b1;
            bus_rs       <= 1'b1;
            bus_data     <= '0;
            bus_cs_n     <= 1'b1;
            bus_reset_n  <= 1'b0;
            lcd_on       <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            step  <= step_n;
            phase <= phase_n;
            if (accept) begin
                px   <= xAddr;
                py   <= yAddr;
                pcol <= pixelData;
            end
            if (win_done) begin
                win_x        <= px;
                win_y        <= py;
                stream_valid <= 1'b1;
            end
            // Track where the panel's cursor lands after this payload.
            if (data_done) begin
                if (x_inc > X_MAX) begin
                    exp_x <= win_x;
                    exp_y <= (y_inc > Y_MAX) ? win_y : y_inc[8:0];
                end else begin
                    exp_x <= x_inc[7:0];
                    exp_y <= py;
                end
            end
            // RS/Data only move when a new write begins; they hold through phase B.
            bus_wr_n <= !(writing_n && !phase_n);
            if (writing_n && !phase_n) begin
                bus_rs   <= word_n[16];
                bus_data <= word_n[15:0];
            end
            bus_cs_n    <= (state_n == RST_HOLD);
            bus_reset_n <= (state_n != RST_HOLD);
            lcd_on      <= (state_n == IDLE) || (state_n == WINDOW) || (state_n == DATA);
            ready       <= (state_n == IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        step_n    = step;
        phase_n   = phase;
        accept    = 1'b0;
        win_done  = 1'b0;
        data_done = 1'b0;
        case (state)
            RST_HOLD: begin
                if (cnt == '0) begin
                    state_n = RST_WAIT;
                    cnt_n   = WAKE_LOAD;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            RST_WAIT: begin
                if (cnt == '0) begin
                    state_n = INIT;
                    step_n  = '0;
                    phase_n = 1'b0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            INIT: begin
                if (step == INIT_WAIT) begin
                    if (cnt == '0) begin
                        step_n  = step + 4'd1;
                        phase_n = 1'b0;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end else if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (step == INIT_LAST) begin
                        state_n = IDLE;
                    end else begin
                        step_n = step + 4'd1;
                        if (step == '0) cnt_n = WAKE_LOAD;
                    end
                end
            end
            IDLE: begin
                if (pixelWrite && ready) begin
                    accept = 1'b1;
                    // Out-of-range requests are swallowed here without touching the bus.
                    if (in_range) begin
                        step_n  = '0;
                        phase_n = 1'b0;
                        state_n = stream_hit ? DATA : WINDOW;
                    end
                end
            end
            WINDOW: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (step == WIN_LAST) begin
                        state_n  = DATA;
                        win_done = 1'b1;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end
            end
            DATA: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n   = 1'b0;
                    state_n   = IDLE;
                    data_done = 1'b1;
                end
            end
            default: state_n = RST_HOLD;
        endcase

        writing_n = ((state_n == INIT) && (step_n != INIT_WAIT)) ||
                    (state_n == WINDOW) || (state_n == DATA);
        word_n    = write_word(state_n, step_n,
                               accept ? xAddr : px,
                               accept ? yAddr : py,
                               accept ? pixelData : pcol);
    end

    always_comb begin
        pixelReady  = ready;
        LT24Wr_n    = bus_wr_n;
        LT24Rd_n    = 1'b1;
        LT24CS_n    = bus_cs_n;
        LT24RS      = bus_rs;
        LT24Reset_n = bus_reset_n;
        LT24Data    = bus_data;
        LT24LCDOn   = lcd_on;
    end

endmodule
